// File: rtl/rfsoc_config.sv
// Shared configuration for the RFSoC DAC data path: bus/counter widths and
// the playback gate state encoding.
package rfsoc_config;

  localparam int BUS_WIDTH = 256;
  localparam int CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    PLAY      = 2'd2
  } playback_state_t;

endpackage

// File: rtl/axis_playback_gate.sv
// Gates a pre-loaded AXI-stream sample buffer onto the DAC stream.
// Armed with a word count, waits for a trigger, then plays exactly that many
// output slots. The DAC stream stays valid at all times: zeros are sent
// outside playback and whenever the FIFO runs dry during playback.
module axis_playback_gate
  import rfsoc_config::*;
#(
  parameter int bus_width = BUS_WIDTH,
  parameter int cnt_width = CNT_WIDTH
) (
  input  logic                 axis_clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [cnt_width-1:0] play_len,
  input  logic                 trigger,
  input  logic                 abort,
  input  logic [bus_width-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [bus_width-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 underflow
);

  localparam logic [cnt_width-1:0] one_c = cnt_width'(1);

  playback_state_t        state_r;
  playback_state_t        state_s;
  logic [cnt_width-1:0]   remaining_r;
  logic [cnt_width-1:0]   remaining_s;
  logic [bus_width-1:0]   data_s;
  logic                   done_s;
  logic                   underflow_s;
  logic                   slot_s;

  // A slot is consumed only in PLAY, with the DAC ready, no abort pending and
  // words still owed; the FIFO is popped on exactly those cycles.
  assign slot_s        = (state_r == PLAY) && m_axis_tready && !abort &&
                         (remaining_r != '0);
  assign s_axis_tready = slot_s;

  // Next-state, counter and output-data decode; abort overrides everything.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    done_s      = 1'b0;
    underflow_s = underflow;
    // Any ready cycle that does not carry a FIFO word emits zeros.
    if (m_axis_tready) begin
      data_s = '0;
    end else begin
      data_s = m_axis_tdata;
    end

    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) begin
            if (play_len == '0) begin
              done_s = 1'b1;
            end else begin
              remaining_s = play_len;
              underflow_s = 1'b0;
              state_s     = WAIT_TRIG;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_TRIG: begin
          if (trigger) begin
            state_s = PLAY;
          end else begin
            state_s = WAIT_TRIG;
          end
        end
        PLAY: begin
          if (slot_s) begin
            remaining_s = remaining_r - one_c;
            if (s_axis_tvalid) begin
              data_s = s_axis_tdata;
            end else begin
              // Empty FIFO: slot still counts so DAC timing is preserved.
              data_s      = '0;
              underflow_s = 1'b1;
            end
            if (remaining_r == one_c) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = PLAY;
            end
          end else if (remaining_r == '0) begin
            // Nothing owed: cannot be reached through arming, recover anyway.
            state_s = IDLE;
          end else begin
            state_s = PLAY;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and play counter registers.
  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      remaining_r <= '0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
    end
  end

  // Registered outputs; tdata only advances on DAC-ready cycles.
  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      m_axis_tdata  <= data_s;
      m_axis_tvalid <= 1'b1;
      busy          <= (state_s != IDLE);
      done          <= done_s;
      underflow     <= underflow_s;
    end
  end

endmodule

// File: tb/tb_axis_playback_gate.sv
// Directed bench for axis_playback_gate: a table of per-cycle vectors plus
// hand-written sequences for back-pressure, abort and mid-play reset.
module tb_axis_playback_gate;

  logic         axis_clk = 1'b0;
  logic         rst;
  logic         arm;
  logic [31:0]  play_len;
  logic         trigger;
  logic         abort;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         busy;
  logic         done;
  logic         underflow;

  int n_chk  = 0;
  int n_pass = 0;

  axis_playback_gate #(.bus_width(256), .cnt_width(32)) dut (
    .axis_clk      (axis_clk),
    .rst           (rst),
    .arm           (arm),
    .play_len      (play_len),
    .trigger       (trigger),
    .abort         (abort),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .underflow     (underflow)
  );

  always #5 axis_clk = ~axis_clk;

  // Upstream FIFO model: word w is presented as 8 copies of a 32-bit tag.
  logic [31:0] fmem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign s_axis_tvalid = (wr_cnt != rd_cnt);
  assign s_axis_tdata  = {8{fmem[rd_cnt % 64]}};

  // FIFO pop on each accepted s-side transfer.
  always @(posedge axis_clk) begin
    if (s_axis_tready && s_axis_tvalid) rd_cnt <= rd_cnt + 1;
  end

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_cnt % 64] = 32'(base + i);
      wr_cnt = wr_cnt + 1;
    end
  endtask

  task automatic flush();
    wr_cnt = rd_cnt;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  typedef struct {
    logic        arm;
    logic [31:0] len;
    logic        trig;
    logic        abort;
    logic        rdy;
    logic        e_busy;
    logic        e_done;
    logic        e_uf;
    logic [31:0] e_data;
    int          e_level;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic a, input int len, input logic t, input logic ab,
                             input logic r, input logic eb, input logic ed, input logic eu,
                             input int edata, input int elev);
    vec_t x;
    x.arm = a; x.len = 32'(len); x.trig = t; x.abort = ab; x.rdy = r;
    x.e_busy = eb; x.e_done = ed; x.e_uf = eu; x.e_data = 32'(edata); x.e_level = elev;
    return x;
  endfunction

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      arm = tbl[i].arm; play_len = tbl[i].len; trigger = tbl[i].trig;
      abort = tbl[i].abort; m_axis_tready = tbl[i].rdy;
      step();
      chk($sformatf("row%0d busy", i), 256'(busy), 256'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i), 256'(done), 256'(tbl[i].e_done));
      chk($sformatf("row%0d underflow", i), 256'(underflow), 256'(tbl[i].e_uf));
      chk($sformatf("row%0d tdata", i), m_axis_tdata, {8{tbl[i].e_data}});
      chk($sformatf("row%0d fifo_level", i), 256'(wr_cnt - rd_cnt), 256'(tbl[i].e_level));
      chk($sformatf("row%0d tvalid", i), 256'(m_axis_tvalid), 256'(1'b1));
    end
    arm = 1'b0; trigger = 1'b0; abort = 1'b0;
  endtask

  int seg1;
  int seg2;
  int idx;
  int done_cnt;
  logic [31:0] exp_w;

  initial begin
    // Table segment 1: 8 words 1..8, arm len 8, trigger 5 cycles later.
    tbl.push_back(v(1, 8, 0, 0, 1, 1, 0, 0, 0, 8));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0, 8));
    tbl.push_back(v(0, 0, 1, 0, 1, 1, 0, 0, 0, 8));
    for (int k = 1; k <= 8; k++) tbl.push_back(v(0, 0, 0, 0, 1, k != 8, k == 8, 0, k, 8 - k));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    seg1 = tbl.size();
    // Segment 2: 4 words 10..13 with len 6, then arm/abort corner cases.
    tbl.push_back(v(1, 6, 0, 0, 1, 1, 0, 0, 0, 4));
    tbl.push_back(v(0, 0, 1, 0, 1, 1, 0, 0, 0, 4));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 10 + k, 3 - k));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 1, 1, 0, 0, 0, 0));   // arm clears underflow
    tbl.push_back(v(1, 7, 0, 0, 1, 1, 0, 0, 0, 0));   // arm in WAIT_TRIG ignored
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));   // abort beats trigger
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 0, 0));   // len 0: done, never busy
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 5, 0, 1, 1, 0, 0, 0, 0, 0));   // arm + abort: stay IDLE
    tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0));   // trigger in IDLE ignored
    seg2 = tbl.size();

    rst = 1'b0; arm = 1'b0; play_len = 32'd0; trigger = 1'b0; abort = 1'b0;
    m_axis_tready = 1'b1;
    step();
    step();
    chk("reset tready", 256'(s_axis_tready), 256'(1'b0));
    chk("reset tdata", m_axis_tdata, 256'd0);
    chk("reset tvalid", 256'(m_axis_tvalid), 256'(1'b0));
    chk("reset busy", 256'(busy), 256'(1'b0));
    chk("reset done", 256'(done), 256'(1'b0));
    chk("reset underflow", 256'(underflow), 256'(1'b0));
    @(negedge axis_clk);
    rst = 1'b1;
    step();
    chk("tvalid after release", 256'(m_axis_tvalid), 256'(1'b1));

    push(8, 1);
    run_table(0, seg1);
    push(4, 10);
    run_table(seg1, seg2);

    // Back-pressure: len 5, ready toggles each cycle, surplus stays in FIFO.
    flush();
    push(7, 20);
    m_axis_tready = 1'b1;
    arm = 1'b1; play_len = 32'd5; step();
    arm = 1'b0; play_len = 32'd0; trigger = 1'b1; step();
    trigger = 1'b0;
    idx = 0; done_cnt = 0; exp_w = 32'd0;
    for (int c = 0; c < 10; c++) begin
      m_axis_tready = (c % 2 == 0);
      step();
      if (m_axis_tready) begin
        exp_w = 32'(20 + idx);
        idx++;
      end
      if (done) done_cnt++;
      chk($sformatf("bp c%0d tdata", c), m_axis_tdata, {8{exp_w}});
      chk($sformatf("bp c%0d done", c), 256'(done), 256'(c == 8));
    end
    chk("bp done count", 256'(done_cnt), 256'd1);
    chk("bp fifo surplus", 256'(wr_cnt - rd_cnt), 256'd2);
    chk("bp busy", 256'(busy), 256'(1'b0));
    m_axis_tready = 1'b1;
    step();
    chk("bp zeros after", m_axis_tdata, 256'd0);

    // Abort two words into a 10-word play.
    flush();
    push(10, 40);
    arm = 1'b1; play_len = 32'd10; step();
    arm = 1'b0; trigger = 1'b1; step();
    trigger = 1'b0; step(); step();
    chk("abort pre tdata", m_axis_tdata, {8{32'd41}});
    abort = 1'b1; step();
    abort = 1'b0;
    chk("abort busy", 256'(busy), 256'(1'b0));
    chk("abort done", 256'(done), 256'(1'b0));
    chk("abort tdata", m_axis_tdata, 256'd0);
    chk("abort fifo level", 256'(wr_cnt - rd_cnt), 256'd8);
    step();
    chk("abort no late done", 256'(done), 256'(1'b0));
    chk("abort fifo kept", 256'(wr_cnt - rd_cnt), 256'd8);
    chk("abort zeros", m_axis_tdata, 256'd0);

    // Reset asserted mid-PLAY.
    flush();
    push(5, 60);
    arm = 1'b1; play_len = 32'd5; step();
    arm = 1'b0; trigger = 1'b1; step();
    trigger = 1'b0; step(); step();
    chk("prerst tdata", m_axis_tdata, {8{32'd61}});
    rst = 1'b0;
    #1;
    chk("midrst tready", 256'(s_axis_tready), 256'(1'b0));
    chk("midrst tdata", m_axis_tdata, 256'd0);
    chk("midrst tvalid", 256'(m_axis_tvalid), 256'(1'b0));
    chk("midrst busy", 256'(busy), 256'(1'b0));
    chk("midrst done", 256'(done), 256'(1'b0));
    step();
    @(negedge axis_clk);
    rst = 1'b1;
    step();
    chk("postrst tvalid", 256'(m_axis_tvalid), 256'(1'b1));
    chk("postrst tdata", m_axis_tdata, 256'd0);
    chk("postrst fifo level", 256'(wr_cnt - rd_cnt), 256'd3);
    trigger = 1'b1; step();
    trigger = 1'b0;
    chk("postrst idle", 256'(busy), 256'(1'b0));
    chk("postrst no pop", 256'(wr_cnt - rd_cnt), 256'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_playback_gate.md
# axis_playback_gate

Gates a pre-loaded AXI-stream sample buffer onto the DAC data path. It sits directly downstream of `axis_sync_fifo` and upstream of the RFDC DAC tile stream. Once armed with a word count, it waits for a trigger, then streams exactly that many 256-bit words out of the FIFO. The DAC stream is never starved: zeros are emitted outside playback and during FIFO underflow.

## Interface
Parameters:
- `bus_width`, 256, AXIS data width; must equal the upstream FIFO `bus_width`.
- `cnt_width`, 32, width of the play-length counter.

Ports:
- `axis_clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous and active-low.
- `arm`  in  1  one-cycle pulse; latches `play_len` and enters WAIT_TRIG.
- `play_len`  in  cnt_width  number of words to play; sampled only on an accepted `arm`.
- `trigger`  in  1  synchronous level; starts playback while in WAIT_TRIG.
- `abort`  in  1  synchronous; returns to IDLE from any state.
- `s_axis_tdata`  in  bus_width  sample words from the FIFO.
- `s_axis_tvalid`  in  1  FIFO word valid.
- `s_axis_tready`  out  1  word consumed.
- `m_axis_tdata`  out  bus_width  DAC sample words (registered).
- `m_axis_tvalid`  out  1  DAC word valid.
- `m_axis_tready`  in  1  DAC ready.
- `busy`  out  1  high in WAIT_TRIG or PLAY.
- `done`  out  1  one-cycle pulse when playback completes.
- `underflow`  out  1  sticky; FIFO was empty during PLAY. Cleared by an accepted `arm`.

## Operation
- States: IDLE, WAIT_TRIG, PLAY.
- IDLE:
  - On `arm`: if `play_len`==0, stay in IDLE and pulse `done` next cycle; otherwise load `remaining` = `play_len`, clear `underflow`, go to WAIT_TRIG.
- WAIT_TRIG:
  - `trigger`=1 moves to PLAY. `arm` is ignored.
- PLAY:
  - `s_axis_tready` = `m_axis_tready`.
  - Each cycle with `m_axis_tready`=1, one output slot is consumed and `remaining` decrements:
    - FIFO valid: the slot takes the FIFO word.
    - FIFO not valid: the slot takes zero and sets `underflow`. The slot still counts, preserving DAC timing.
  - When the slot that decrements `remaining` from 1 to 0 is consumed, go to IDLE and pulse `done` next cycle.
- `abort` has priority over all other events, including a simultaneous `arm` or `trigger`. It forces IDLE with no `done` pulse. Words remaining in the FIFO are left untouched.
- `arm` outside IDLE is ignored. `play_len` changes after arming have no effect.
- Outside PLAY: `s_axis_tready`=0 and `m_axis_tdata` is loaded with zeros.
- `m_axis_tvalid` is held at 1 from the first cycle after reset release (continuous DAC stream).
- Reset mid-playback: immediate return to IDLE and reset output values, regardless of state.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tdata`=0, `m_axis_tvalid`=0, `busy`=0, `done`=0, `underflow`=0, state IDLE, `remaining`=0.
- `arm` sampled at cycle 0 → `busy`=1 and WAIT_TRIG at cycle 1.
- `trigger` sampled high at cycle t → PLAY at t+1; `s_axis_tready` can assert at t+1.
- Data latency: a word transferred on the s-side at cycle k appears on `m_axis_tdata` at k+1.
- `m_axis_tdata` and `m_axis_tvalid` update only when `m_axis_tready`=1. They hold while `m_axis_tready`=0.
- Last slot consumed at cycle n → at n+1: state IDLE, `busy`=0, `done`=1, last word on `m_axis_tdata`. The following ready cycle outputs zeros.
- Counter width: `remaining` is cnt_width bits and never wraps; a decrement occurs only when `remaining` > 0.

## Structure
- Add `playback_state_t` (IDLE, WAIT_TRIG, PLAY) to package `rfsoc_config`, alongside the existing shared constants.
- Single module with no sub-module. The counter, FSM and output register are inline.

## Test plan
- Load 8 words 1..8 into the FIFO; `arm` with `play_len`=8; `trigger` 5 cycles later, `m_axis_tready`=1 → output shows 1..8 starting 2 cycles after trigger, `done` pulses once, FIFO empty, `underflow`=0, then zeros.
- Load 4 words; `play_len`=6 → output shows 4 data words then 2 zero words; `underflow`=1 until the next `arm`.
- `play_len`=5; toggle `m_axis_tready` 1/0 each cycle during PLAY → exactly 5 words appear in order, each held while ready is low, no duplicates, FIFO retains the surplus.
- `abort` two words into a 10-word play → IDLE next cycle, no `done`, 8 words remain in the FIFO, output zeros.
- `arm` with `play_len`=0 → `done` next cycle, `busy` never asserts. `arm` and `abort` in the same cycle → stays IDLE.
- Deassert `rst` mid-PLAY → all outputs at reset values immediately, IDLE after release, `m_axis_tvalid`=1 one cycle after release.
